// File: rtl/edge_event_arbiter.sv
// Edge-detecting event arbiter: per-channel rising edges become pending
// events served round-robin over a valid/ready port. Optional EDGE_EVENT_ARBITER_OVF_EN.
module edge_event_arbiter #(
  parameter int N_CH = 4,
  localparam int W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] signal,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [W-1:0]    ev_ch,
  output logic [N_CH-1:0] pend,
  output logic [N_CH-1:0] ovf,
  input  logic            ovf_clr
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_e;

  localparam logic [W:0] NC = (W+1)'(N_CH);

  state_e          state_q, state_d;
  logic [N_CH-1:0] sig_prev_q;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [W-1:0]    ev_ch_q, ev_ch_d;
  logic [W-1:0]    rr_q, rr_d;

  logic [N_CH-1:0]   rise;
  logic [2*N_CH-1:0] rot2;
  logic [N_CH-1:0]   rot;
  logic              found;
  logic [W-1:0]      win_off;
  logic [W:0]        win_sum;
  logic [W-1:0]      winner;
  logic [W:0]        nxt_sum;
  logic              load;
  logic [N_CH-1:0]   clr_mask;

  assign rise = signal & ~sig_prev_q;

  // Round-robin search: rotate pending bits so rr_q lands at bit 0
  always_comb begin
    rot2    = {pend_q, pend_q} >> rr_q;
    rot     = rot2[N_CH-1:0];
    found   = 1'b0;
    win_off = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!found && rot[k]) begin
        found   = 1'b1;
        win_off = k[W-1:0];
      end
    end
    win_sum = {1'b0, rr_q} + {1'b0, win_off};
    if (win_sum >= NC) win_sum = win_sum - NC;
    winner  = win_sum[W-1:0];
    nxt_sum = {1'b0, winner} + {{W{1'b0}}, 1'b1};
    if (nxt_sum >= NC) nxt_sum = '0;
  end

  // Presentation FSM: load a winner when idle or when the current event is taken
  always_comb begin
    state_d  = state_q;
    ev_ch_d  = ev_ch_q;
    rr_d     = rr_q;
    load     = 1'b0;
    clr_mask = '0;
    unique case (state_q)
      S_IDLE: begin
        load = found;
      end
      S_PRESENT: begin
        if (ev_ready) begin
          load = found;
          if (!found) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load) begin
      state_d          = S_PRESENT;
      ev_ch_d          = winner;
      rr_d             = nxt_sum[W-1:0];
      clr_mask[winner] = 1'b1;
    end
  end

  // A rise in the same cycle as a grant re-arms the pending bit
  always_comb begin
    pend_d = (pend_q & ~clr_mask) | rise;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sig_prev_q <= '0;
      pend_q     <= '0;
      ev_ch_q    <= '0;
      rr_q       <= '0;
    end else begin
      state_q    <= state_d;
      sig_prev_q <= signal;
      pend_q     <= pend_d;
      ev_ch_q    <= ev_ch_d;
      rr_q       <= rr_d;
    end
  end

  assign ev_valid = (state_q == S_PRESENT);
  assign ev_ch    = ev_ch_q;
  assign pend     = pend_q;

`ifdef EDGE_EVENT_ARBITER_OVF_EN
  logic [N_CH-1:0] ovf_q, ovf_d;

  // Sticky overflow: a rise merged into a still-pending bit; set beats clear
  always_comb begin
    ovf_d = (ovf_clr ? '0 : ovf_q) | (rise & pend_q & ~clr_mask);
  end

  // Overflow flag register
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= '0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf = '0;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (N_CH=4).
// Overflow expectations follow EDGE_EVENT_ARBITER_OVF_EN.
module tb_edge_event_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] signal;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_ch;
  logic [3:0] pend;
  logic [3:0] ovf;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;

`ifdef EDGE_EVENT_ARBITER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  edge_event_arbiter #(.N_CH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .signal   (signal),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_ch    (ev_ch),
    .pend     (pend),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic out(input string tag, input logic v,
                     input logic [1:0] ch, input logic [3:0] p);
    chk({tag, ".valid"}, {31'b0, ev_valid}, {31'b0, v});
    if (v) chk({tag, ".ch"}, {30'b0, ev_ch}, {30'b0, ch});
    chk({tag, ".pend"}, {28'b0, pend}, {28'b0, p});
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    signal   = 4'b0000;
    ev_ready = 1'b1;
    ovf_clr  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst.valid", {31'b0, ev_valid}, 32'd0);
    chk("rst.pend", {28'b0, pend}, 32'd0);
    chk("rst.ch", {30'b0, ev_ch}, 32'd0);
    chk("rst.ovf", {28'b0, ovf}, 32'd0);
    tick();

    // Single edge on ch2
    signal = 4'b0100;
    tick(); out("single.s1", 1'b0, 2'd0, 4'b0100);
    tick(); out("single.s2", 1'b1, 2'd2, 4'b0000);
    tick(); out("single.s3", 1'b0, 2'd0, 4'b0000);
    signal = 4'b0000;
    tick();

    // Simultaneous edges on all channels
    do_reset();
    signal = 4'b1111;
    tick(); out("sim.p", 1'b0, 2'd0, 4'b1111);
    tick(); out("sim.g0", 1'b1, 2'd0, 4'b1110);
    tick(); out("sim.g1", 1'b1, 2'd1, 4'b1100);
    tick(); out("sim.g2", 1'b1, 2'd2, 4'b1000);
    tick(); out("sim.g3", 1'b1, 2'd3, 4'b0000);
    tick(); out("sim.end", 1'b0, 2'd0, 4'b0000);

    // Wrap: after ch3 grant, ch0 beats ch3
    signal = 4'b0000;
    tick();
    signal = 4'b1001;
    tick(); out("wrap.p", 1'b0, 2'd0, 4'b1001);
    tick(); out("wrap.g0", 1'b1, 2'd0, 4'b1000);
    tick(); out("wrap.g3", 1'b1, 2'd3, 4'b0000);
    tick(); out("wrap.end", 1'b0, 2'd0, 4'b0000);

    // Backpressure on ch1/ch3
    do_reset();
    ev_ready = 1'b0;
    signal   = 4'b1010;
    tick(); out("bp.p", 1'b0, 2'd0, 4'b1010);
    for (int i = 0; i < 5; i++) begin
      tick(); out($sformatf("bp.hold%0d", i), 1'b1, 2'd1, 4'b1000);
    end
    ev_ready = 1'b1;
    tick(); out("bp.g3", 1'b1, 2'd3, 4'b0000);
    tick(); out("bp.end", 1'b0, 2'd0, 4'b0000);

    // Merge and rise-during-grant on ch1
    do_reset();
    ev_ready = 1'b0;
    signal   = 4'b0011;
    tick(); out("mg.p", 1'b0, 2'd0, 4'b0011);
    tick(); out("mg.g0", 1'b1, 2'd0, 4'b0010);
    signal = 4'b0000;
    tick();
    signal = 4'b0010;
    tick(); out("mg.merge", 1'b1, 2'd0, 4'b0010);
    chk("mg.ovf", {28'b0, ovf}, OVF_ON ? 32'h2 : 32'h0);
    signal = 4'b0000;
    tick();
    signal   = 4'b0010;
    ev_ready = 1'b1;
    tick(); out("mg.regrant", 1'b1, 2'd1, 4'b0010);
    chk("mg.ovf2", {28'b0, ovf}, OVF_ON ? 32'h2 : 32'h0);
    signal = 4'b0000;
    tick(); out("mg.again", 1'b1, 2'd1, 4'b0000);
    tick(); out("mg.end", 1'b0, 2'd0, 4'b0000);
    ovf_clr = 1'b1;
    tick(); chk("mg.ovfclr", {28'b0, ovf}, 32'd0);
    ovf_clr = 1'b0;

    // Overflow on ch0 while ch1 is held
    do_reset();
    ev_ready = 1'b0;
    signal   = 4'b0010;
    tick();
    tick(); out("of.g1", 1'b1, 2'd1, 4'b0000);
    signal = 4'b0011;
    tick(); out("of.r1", 1'b1, 2'd1, 4'b0001);
    signal = 4'b0010;
    tick();
    signal = 4'b0011;
    tick(); out("of.r2", 1'b1, 2'd1, 4'b0001);
    chk("of.ovf", {28'b0, ovf}, OVF_ON ? 32'h1 : 32'h0);
    ev_ready = 1'b1;
    tick(); out("of.g0", 1'b1, 2'd0, 4'b0000);
    tick(); out("of.end", 1'b0, 2'd0, 4'b0000);
    chk("of.sticky", {28'b0, ovf}, OVF_ON ? 32'h1 : 32'h0);
    ovf_clr = 1'b1;
    tick(); chk("of.clr", {28'b0, ovf}, 32'd0);
    ovf_clr = 1'b0;

    // Reset mid-handshake discards events; high level after release is an edge
    do_reset();
    ev_ready = 1'b0;
    signal   = 4'b0110;
    tick();
    tick(); out("mr.pre", 1'b1, 2'd1, 4'b0100);
    rst_n    = 1'b0;
    ev_ready = 1'b1;
    tick(); out("mr.rst", 1'b0, 2'd0, 4'b0000);
    chk("mr.rstch", {30'b0, ev_ch}, 32'd0);
    rst_n = 1'b1;
    tick(); out("mr.edge", 1'b0, 2'd0, 4'b0110);
    tick(); out("mr.g1", 1'b1, 2'd1, 4'b0100);
    tick(); out("mr.g2", 1'b1, 2'd2, 4'b0000);
    tick(); out("mr.end", 1'b0, 2'd0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
